// File: rtl/swerv_types.sv
// Shared types and widths for the LSU bus-clock ratio controller.
package swerv_types;

    localparam int LSU_BUSCLK_RATIO_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        SWITCH = 2'd2
    } busclk_state_t;

endpackage

// File: rtl/lsu_busclk_ctl.sv
// LSU bus clock-enable divider with a drain-then-switch sequencer for runtime
// changes of the core:bus ratio.
module lsu_busclk_ctl
    import swerv_types::*;
#(
    parameter int RATIO_W       = LSU_BUSCLK_RATIO_W,
    parameter int DEFAULT_RATIO = 0,
    parameter int IDLE_HOLD     = 4
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic [RATIO_W-1:0] ratio_cfg,
    input  logic               ratio_cfg_wr,
    input  logic               bus_idle,
    output logic               lsu_bus_clk_en,
    output logic [RATIO_W-1:0] ratio_cur,
    output logic               cfg_pend,
    output logic               lsu_bus_req_block,
    output logic               cfg_ack
);

    localparam logic [RATIO_W-1:0] DEF_RATIO = RATIO_W'(DEFAULT_RATIO);
    localparam logic [3:0]         HOLD      = 4'(IDLE_HOLD);

    busclk_state_t      state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] ratio_cur_q, ratio_cur_d;
    logic [RATIO_W-1:0] ratio_new_q, ratio_new_d;
    logic [3:0]         idle_cnt_q, idle_cnt_d;
    logic               cfg_ack_q, cfg_ack_d;
    logic               bus_clk_en;

    assign bus_clk_en = (cnt_q == ratio_cur_q);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            ratio_cur_q <= DEF_RATIO;
            ratio_new_q <= DEF_RATIO;
            idle_cnt_q  <= '0;
            cfg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ratio_cur_q <= ratio_cur_d;
            ratio_new_q <= ratio_new_d;
            idle_cnt_q  <= idle_cnt_d;
            cfg_ack_q   <= cfg_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ratio_cur_d = ratio_cur_q;
        ratio_new_d = ratio_new_q;
        idle_cnt_d  = idle_cnt_q;
        cfg_ack_d   = 1'b0;
        cnt_d       = bus_clk_en ? '0 : cnt_q + 1'b1;

        case (state_q)
            RUN: begin
                if (ratio_cfg_wr) begin
                    if (ratio_cfg == ratio_cur_q) begin
                        cfg_ack_d = 1'b1;
                    end else begin
                        ratio_new_d = ratio_cfg;
                        idle_cnt_d  = '0;
                        state_d     = PEND;
                    end
                end
            end
            PEND: begin
                // A new write overrides any idle progress made so far.
                if (ratio_cfg_wr) begin
                    if (ratio_cfg == ratio_cur_q) begin
                        cfg_ack_d = 1'b1;
                        state_d   = RUN;
                    end else begin
                        ratio_new_d = ratio_cfg;
                        idle_cnt_d  = '0;
                    end
                end else if (bus_clk_en && (idle_cnt_q == HOLD)) begin
                    state_d = SWITCH;
                end else if (!bus_idle) begin
                    idle_cnt_d = '0;
                end else if (bus_clk_en) begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                end
            end
            SWITCH: begin
                ratio_cur_d = ratio_new_q;
                cnt_d       = '0;
                cfg_ack_d   = 1'b1;
                state_d     = RUN;
                // The incoming ratio is the reference for a write landing here.
                if (ratio_cfg_wr && (ratio_cfg != ratio_new_q)) begin
                    ratio_new_d = ratio_cfg;
                    idle_cnt_d  = '0;
                    state_d     = PEND;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign lsu_bus_clk_en    = bus_clk_en;
    assign ratio_cur         = ratio_cur_q;
    assign cfg_pend          = (state_q != RUN);
    assign lsu_bus_req_block = (state_q != RUN);
    assign cfg_ack           = cfg_ack_q;

endmodule

// File: tb/tb_lsu_busclk_ctl.sv
// Scenario bench for lsu_busclk_ctl; acked ratios are checked against a queue.
module tb_lsu_busclk_ctl;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [2:0] ratio_cfg;
    logic       ratio_cfg_wr;
    logic       bus_idle;
    logic       lsu_bus_clk_en;
    logic [2:0] ratio_cur;
    logic       cfg_pend;
    logic       lsu_bus_req_block;
    logic       cfg_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    logic [2:0] exp_q[$];

    lsu_busclk_ctl #(.RATIO_W(3), .DEFAULT_RATIO(0), .IDLE_HOLD(4)) dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .ratio_cfg         (ratio_cfg),
        .ratio_cfg_wr      (ratio_cfg_wr),
        .bus_idle          (bus_idle),
        .lsu_bus_clk_en    (lsu_bus_clk_en),
        .ratio_cur         (ratio_cur),
        .cfg_pend          (cfg_pend),
        .lsu_bus_req_block (lsu_bus_req_block),
        .cfg_ack           (cfg_ack)
    );

    always #5 clk = ~clk;

    // Every ack must retire exactly one queued ratio write.
    always @(posedge clk) begin
        logic [2:0] exp_r;
        #1;
        if (rst_l === 1'b1 && cfg_ack === 1'b1) begin
            ack_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL ack_unexpected: got cfg_ack=1 ratio_cur=%0d, required no ack", ratio_cur);
                n_fail++;
            end else begin
                exp_r = exp_q.pop_front();
                $display("ack: ratio_cur=%0d expected=%0d", ratio_cur, exp_r);
                if (ratio_cur !== exp_r) begin
                    $display("FAIL ack_ratio: got %0d required %0d", ratio_cur, exp_r);
                    n_fail++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst_l = 1'b0; bus_idle = 1'b1; ratio_cfg_wr = 1'b0; ratio_cfg = 3'd0;
        #12;
        n_checks++;
        if ({lsu_bus_clk_en, ratio_cur, cfg_pend, lsu_bus_req_block, cfg_ack} !== 7'b1_000_000) begin
            $display("FAIL reset_outputs: got en=%b ratio=%0d pend=%b blk=%b ack=%b required en=1 ratio=0 others 0",
                     lsu_bus_clk_en, ratio_cur, cfg_pend, lsu_bus_req_block, cfg_ack);
            n_fail++;
        end
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (lsu_bus_clk_en !== 1'b1 || ratio_cur !== 3'd0 || cfg_ack !== 1'b0) begin
                $display("FAIL reset_run: cycle %0d got en=%b ratio=%0d ack=%b required 1/0/0",
                         i, lsu_bus_clk_en, ratio_cur, cfg_ack);
                n_fail++;
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_ratio3;
        int n;
        logic exp_en;
        exp_q.push_back(3'd3);
        ratio_cfg = 3'd3; ratio_cfg_wr = 1'b1;
        tick();
        ratio_cfg_wr = 1'b0;
        n_checks++;
        if (cfg_pend !== 1'b1 || lsu_bus_req_block !== 1'b1 || cfg_ack !== 1'b0) begin
            $display("FAIL r3_pend: got pend=%b blk=%b ack=%b required 1/1/0", cfg_pend, lsu_bus_req_block, cfg_ack);
            n_fail++;
        end
        n = 0;
        while (cfg_ack !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 6) begin
            $display("FAIL r3_latency: got %0d cycles to ack required 6", n);
            n_fail++;
        end
        n_checks++;
        if (ratio_cur !== 3'd3 || cfg_pend !== 1'b0 || lsu_bus_req_block !== 1'b0) begin
            $display("FAIL r3_applied: got ratio=%0d pend=%b blk=%b required 3/0/0", ratio_cur, cfg_pend, lsu_bus_req_block);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            exp_en = ((i % 4) == 3);
            n_checks++;
            if (lsu_bus_clk_en !== exp_en) begin
                $display("FAIL r3_div: cycle %0d got en=%b required %b", i, lsu_bus_clk_en, exp_en);
                n_fail++;
            end
            tick();
        end
        $display("test_ratio3 done");
    endtask

    task automatic test_ratio1_busy;
        int beats, g, bad;
        exp_q.push_back(3'd1);
        bus_idle = 1'b0;
        ratio_cfg = 3'd1; ratio_cfg_wr = 1'b1;
        tick();
        ratio_cfg_wr = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (cfg_pend !== 1'b1 || lsu_bus_req_block !== 1'b1 || ratio_cur !== 3'd3) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL r1_busy_hold: got %0d bad cycles required 0", bad);
            n_fail++;
        end
        bus_idle = 1'b1;
        beats = 0; g = 0;
        while (beats < 2 && g < 100) begin
            if (lsu_bus_clk_en === 1'b1) beats++;
            tick();
            g++;
        end
        bus_idle = 1'b0;
        tick();
        bus_idle = 1'b1;
        beats = 0; g = 0;
        while (cfg_ack !== 1'b1 && g < 200) begin
            if (lsu_bus_clk_en === 1'b1) beats++;
            tick();
            g++;
        end
        n_checks++;
        if (beats != 5) begin
            $display("FAIL r1_idle_beats: got %0d beats before ack required 5", beats);
            n_fail++;
        end
        n_checks++;
        if (ratio_cur !== 3'd1) begin
            $display("FAIL r1_applied: got ratio=%0d required 1", ratio_cur);
            n_fail++;
        end
        $display("test_ratio1_busy done");
    endtask

    task automatic test_retarget;
        int beats, g, acks0;
        acks0 = ack_cnt;
        exp_q.push_back(3'd5);
        ratio_cfg = 3'd2; ratio_cfg_wr = 1'b1;
        tick();
        ratio_cfg_wr = 1'b0;
        beats = 0; g = 0;
        while (beats < 3 && g < 100) begin
            if (lsu_bus_clk_en === 1'b1) beats++;
            tick();
            g++;
        end
        ratio_cfg = 3'd5; ratio_cfg_wr = 1'b1;
        tick();
        ratio_cfg_wr = 1'b0;
        beats = 0; g = 0;
        while (cfg_ack !== 1'b1 && g < 200) begin
            if (lsu_bus_clk_en === 1'b1) beats++;
            tick();
            g++;
        end
        n_checks++;
        if (beats != 5) begin
            $display("FAIL retarget_beats: got %0d beats required 5", beats);
            n_fail++;
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (ack_cnt != acks0 + 1 || ratio_cur !== 3'd5) begin
            $display("FAIL retarget_ack: got acks=%0d ratio=%0d required acks=1 ratio=5", ack_cnt - acks0, ratio_cur);
            n_fail++;
        end
        $display("test_retarget done");
    endtask

    task automatic test_same_value;
        int g, acks0;
        logic exp_en;
        acks0 = ack_cnt;
        for (int pass = 0; pass < 2; pass++) begin
            g = 0;
            while (lsu_bus_clk_en !== 1'b1 && g < 50) begin
                tick();
                g++;
            end
            if (pass == 0) begin
                tick();
            end else begin
                ratio_cfg = 3'd7; ratio_cfg_wr = 1'b1;
                tick();
                n_checks++;
                if (cfg_pend !== 1'b1 || lsu_bus_req_block !== 1'b1) begin
                    $display("FAIL same_pend_entry: got pend=%b blk=%b required 1/1", cfg_pend, lsu_bus_req_block);
                    n_fail++;
                end
            end
            exp_q.push_back(3'd5);
            ratio_cfg = 3'd5; ratio_cfg_wr = 1'b1;
            tick();
            ratio_cfg_wr = 1'b0;
            n_checks++;
            if (cfg_ack !== 1'b1 || cfg_pend !== 1'b0 || lsu_bus_req_block !== 1'b0 || ratio_cur !== 3'd5) begin
                $display("FAIL same_ack_p%0d: got ack=%b pend=%b blk=%b ratio=%0d required 1/0/0/5",
                         pass, cfg_ack, cfg_pend, lsu_bus_req_block, ratio_cur);
                n_fail++;
            end
            for (int off = 2; off <= 6; off++) begin
                exp_en = (off == 6);
                n_checks++;
                if (lsu_bus_clk_en !== exp_en) begin
                    $display("FAIL same_cnt_p%0d: offset %0d got en=%b required %b", pass, off, lsu_bus_clk_en, exp_en);
                    n_fail++;
                end
                if (off < 6) tick();
            end
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (ack_cnt != acks0 + 2) begin
            $display("FAIL same_ack_count: got %0d required 2", ack_cnt - acks0);
            n_fail++;
        end
        $display("test_same_value done");
    endtask

    task automatic test_reset_mid_pend;
        int acks0;
        ratio_cfg = 3'd2; ratio_cfg_wr = 1'b1;
        tick();
        ratio_cfg_wr = 1'b0;
        n_checks++;
        if (cfg_pend !== 1'b1) begin
            $display("FAIL rst_pend_entry: got pend=%b required 1", cfg_pend);
            n_fail++;
        end
        #1 rst_l = 1'b0;
        #1;
        n_checks++;
        if ({lsu_bus_clk_en, ratio_cur, cfg_pend, lsu_bus_req_block, cfg_ack} !== 7'b1_000_000) begin
            $display("FAIL rst_async: got en=%b ratio=%0d pend=%b blk=%b ack=%b required en=1 ratio=0 others 0",
                     lsu_bus_clk_en, ratio_cur, cfg_pend, lsu_bus_req_block, cfg_ack);
            n_fail++;
        end
        tick();
        tick();
        @(negedge clk);
        rst_l = 1'b1;
        acks0 = ack_cnt;
        for (int i = 0; i < 30; i++) tick();
        n_checks++;
        if (ack_cnt != acks0 || ratio_cur !== 3'd0 || cfg_pend !== 1'b0) begin
            $display("FAIL rst_discard: got acks=%0d ratio=%0d pend=%b required 0/0/0", ack_cnt - acks0, ratio_cur, cfg_pend);
            n_fail++;
        end
        $display("test_reset_mid_pend done");
    endtask

    initial begin
        test_reset();
        test_ratio3();
        test_ratio1_busy();
        test_retarget();
        test_same_value();
        test_reset_mid_pend();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
